// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults, queue entry type and width helper for the instruction-fetch stage.
package if_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int INCR_DEF   = 4;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0] pc;
    } fetch_entry_t;

    // Bits needed to hold an occupancy from 0 up to and including depth.
    function automatic int count_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side valid/ready handshake.
interface if_fetch_queue_if import if_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = count_w(4)
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_next;
    logic [CNT_W-1:0]  count;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_next, count,
        input  imem_rdata, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_next, count,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop in the same cycle.
module fetch_fifo import if_pkg::*; #(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int CNT_W   = count_w(DEPTH),
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  entry_t           din,
    output entry_t           dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC + increment, 1-cycle imem read, DEPTH-entry queue toward decode, redirect flush.
module if_fetch_queue import if_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int INCR   = INCR_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    if_fetch_queue_if.master  bus
);
    localparam int CNT_W = count_w(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    entry_t            push_entry;
    entry_t            head;

    // The read in flight already owns a slot, so it counts against the queue; a pop this cycle does not free one.
    assign occupancy  = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue      = fetch_en && !redirect_valid && !reset && !full
                        && (occupancy < (CNT_W+1)'(DEPTH));
    assign push       = inflight && !redirect_valid;
    assign head_valid = !empty && !redirect_valid;
    assign pop        = head_valid && bus.out_ready;
    assign push_entry = '{instr: bus.imem_rdata, pc: inflight_pc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(INCR);
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // Storage behind an empty head is stale, so the head fields are forced to zero.
    assign bus.imem_en     = issue;
    assign bus.imem_addr   = pc;
    assign bus.out_valid   = head_valid;
    assign bus.out_instr   = empty ? '0 : head.instr;
    assign bus.out_pc      = empty ? '0 : head.pc;
    assign bus.out_pc_next = empty ? '0 : head.pc + ADDR_W'(INCR);
    assign bus.count       = count;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised scoreboard bench: DEPTH=4/RESET_PC=0 and DEPTH=2/RESET_PC=0xFFFFFFF8 side by side.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;
    localparam int D0 = 4;
    localparam int D1 = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(count_w(D0))) b0 ();
    if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(count_w(D1))) b1 ();

    if_fetch_queue #(.DEPTH(D0), .RESET_PC(RPC0)) u0 (
        .clock(clock), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(b0.master));
    if_fetch_queue #(.DEPTH(D1), .RESET_PC(RPC1)) u1 (
        .clock(clock), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(b1.master));

    assign b0.out_ready = out_ready;
    assign b1.out_ready = out_ready;

    // Instruction memory: mem[k] = k+1, one cycle read latency.
    always @(posedge clock) if (b0.imem_en) b0.imem_rdata <= (b0.imem_addr >> 2) + 32'd1;
    always @(posedge clock) if (b1.imem_en) b1.imem_rdata <= (b1.imem_addr >> 2) + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: the address stream decode must see after each reset or redirect.
    logic [31:0] exq0[$];
    logic [31:0] exq1[$];

    task automatic restart(input logic [31:0] t0, input logic [31:0] t1);
        exq0.delete();
        exq1.delete();
        for (int k = 0; k < 600; k++) begin
            exq0.push_back(t0 + 32'(4 * k));
            exq1.push_back(t1 + 32'(4 * k));
        end
    endtask

    // Abstract occupancy model: entries held, read outstanding, next fetch address.
    int          m_cnt [2];
    bit          m_infl [2];
    logic [31:0] m_pc [2];
    int          deliv [2];

    task automatic step(input int i, input logic en, input logic [31:0] addr, input logic ov,
                        input logic [31:0] instr, input logic [31:0] opc, input logic [31:0] opcn,
                        input int cnt);
        int          dep;
        logic [31:0] rpc;
        logic [31:0] epc;
        bit          exp_issue;
        bit          exp_valid;
        bit          have;
        dep = (i == 0) ? D0 : D1;
        rpc = (i == 0) ? RPC0 : RPC1;
        if (reset) begin
            chk($sformatf("u%0d_rst_en_valid", i), {30'b0, en, ov}, 32'd0);
            chk($sformatf("u%0d_rst_count", i), 32'(cnt), 32'd0);
            chk($sformatf("u%0d_rst_head", i), instr | opc | opcn, 32'd0);
            m_cnt[i] = 0;
            m_infl[i] = 1'b0;
            m_pc[i] = rpc;
            return;
        end
        exp_issue = fetch_en && !redirect_valid && (m_cnt[i] + int'(m_infl[i]) < dep);
        exp_valid = (m_cnt[i] > 0) && !redirect_valid;
        chk($sformatf("u%0d_imem_en", i), 32'(en), 32'(exp_issue));
        chk($sformatf("u%0d_imem_addr", i), addr, m_pc[i]);
        chk($sformatf("u%0d_count", i), 32'(cnt), 32'(m_cnt[i]));
        chk($sformatf("u%0d_out_valid", i), 32'(ov), 32'(exp_valid));
        if (m_cnt[i] == 0) chk($sformatf("u%0d_empty_head", i), instr | opc | opcn, 32'd0);
        if (ov && out_ready) begin
            deliv[i]++;
            have = (i == 0) ? (exq0.size() > 0) : (exq1.size() > 0);
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL u%0d_unexpected_delivery actual_pc=%h required=none", i, opc);
            end else begin
                epc = (i == 0) ? exq0.pop_front() : exq1.pop_front();
                chk($sformatf("u%0d_out_pc", i), opc, epc);
                chk($sformatf("u%0d_out_instr", i), instr, (epc >> 2) + 32'd1);
                chk($sformatf("u%0d_out_pc_next", i), opcn, epc + 32'd4);
            end
        end
        if (redirect_valid) begin
            m_cnt[i] = 0;
            m_infl[i] = 1'b0;
            m_pc[i] = redirect_pc;
        end else begin
            m_cnt[i] = m_cnt[i] + int'(m_infl[i]) - int'(exp_valid && out_ready);
            m_infl[i] = exp_issue;
            if (exp_issue) m_pc[i] = m_pc[i] + 32'd4;
        end
    endtask

    always @(negedge clock) begin
        step(0, b0.imem_en, b0.imem_addr, b0.out_valid, b0.out_instr, b0.out_pc, b0.out_pc_next,
             int'(b0.count));
        step(1, b1.imem_en, b1.imem_addr, b1.out_valid, b1.out_instr, b1.out_pc, b1.out_pc_next,
             int'(b1.count));
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int d0;
        repeat (3) cyc();
        restart(RPC0, RPC1);
        reset = 1'b0;

        // Straight-line fetch with decode always ready.
        fetch_en = 1'b1;
        out_ready = 1'b1;
        repeat (12) cyc();
        d0 = deliv[0];
        repeat (20) cyc();
        chk("u0_throughput", 32'(deliv[0] - d0), 32'd20);

        // Back-pressure fills the queue, then drains in order.
        out_ready = 1'b0;
        repeat (10) cyc();
        chk("u0_full_count", 32'(b0.count), 32'd4);
        chk("u0_full_no_issue", 32'(b0.imem_en), 32'd0);
        chk("u1_full_count", 32'(b1.count), 32'd2);
        out_ready = 1'b1;
        repeat (6) cyc();

        // Redirect to 0x40 with three entries queued and a read outstanding.
        out_ready = 1'b0;
        for (int k = 0; k < 20 && b0.count != 3; k++) cyc();
        chk("u0_reach_count3", 32'(b0.count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        restart(32'h40, 32'h40);
        #1 chk("u0_redir_valid_low", 32'(b0.out_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("u0_redir_count0", 32'(b0.count), 32'd0);
        chk("u0_redir_issue_en", 32'(b0.imem_en), 32'd1);
        chk("u0_redir_issue_addr", b0.imem_addr, 32'h40);
        cyc();
        #1 chk("u0_redir_wait_valid", 32'(b0.out_valid), 32'd0);
        cyc();
        #1;
        chk("u0_redir_first_valid", 32'(b0.out_valid), 32'd1);
        chk("u0_redir_first_pc", b0.out_pc, 32'h40);
        chk("u0_redir_first_instr", b0.out_instr, 32'd17);

        // Fetch disable: outstanding read lands, pc holds, then resumes.
        cyc();
        fetch_en = 1'b0;
        out_ready = 1'b0;
        repeat (6) cyc();
        out_ready = 1'b1;
        repeat (3) cyc();
        fetch_en = 1'b1;
        repeat (10) cyc();

        // Random traffic with occasional redirects and one mid-run reset.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                reset = 1'b1;
                redirect_valid = 1'b0;
                #1;
                chk("u0_async_rst_valid", 32'(b0.out_valid), 32'd0);
                chk("u0_async_rst_count", 32'(b0.count), 32'd0);
                chk("u0_async_rst_en", 32'(b0.imem_en), 32'd0);
                chk("u1_async_rst_valid", 32'(b1.out_valid), 32'd0);
                chk("u1_async_rst_count", 32'(b1.count), 32'd0);
                cyc();
                cyc();
                restart(RPC0, RPC1);
                reset = 1'b0;
            end
            fetch_en = ($urandom_range(0, 99) < 85);
            out_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 5) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
                restart(redirect_pc, redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            cyc();
        end

        redirect_valid = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b1;
        repeat (8) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
